// File: rtl/data_memory_arbiter.sv
// Two-requester arbiter in front of a single-port data memory.
// Round-robin on contention, one transaction in flight, registered strobes and acks.
module data_memory_arbiter #(
  parameter int DEPTH = 256
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        MemWrite,
  output logic        MemRead,
  output logic [31:0] address,
  output logic [31:0] write_data,
  input  logic [31:0] read_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state, state_next;
  logic        cur_id;
  logic        cur_we;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic        err_flag;
  logic        last_grant;
  logic        grant_id;
  logic        in_range;

  // On contention the requester that did not win last time goes first.
  assign grant_id = (req0 && req1) ? ~last_grant : req1;
  assign in_range = (cur_addr < 32'(DEPTH));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: every combinational output gets a default before the case so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req0 || req1) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes and acks are registered, so each appears one cycle after the state that
  // decides it: strobes while the FSM sits in RESP, ack while it is back in IDLE.
  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur_id     <= 1'b0;
      cur_we     <= 1'b0;
      cur_addr   <= '0;
      cur_wdata  <= '0;
      err_flag   <= 1'b0;
      last_grant <= 1'b1;
      MemWrite   <= 1'b0;
      MemRead    <= 1'b0;
      address    <= '0;
      write_data <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      err0       <= 1'b0;
      err1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      MemWrite <= 1'b0;
      MemRead  <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      err0     <= 1'b0;
      err1     <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            cur_id     <= grant_id;
            cur_we     <= grant_id ? we1    : we0;
            cur_addr   <= grant_id ? addr1  : addr0;
            cur_wdata  <= grant_id ? wdata1 : wdata0;
            last_grant <= grant_id;
          end
        end
        ACCESS: begin
          err_flag <= ~in_range;
          // Out-of-range accesses never touch the memory bus; address keeps its last value.
          if (in_range) begin
            MemWrite   <= cur_we;
            MemRead    <= ~cur_we;
            address    <= cur_addr;
            write_data <= cur_wdata;
          end
        end
        RESP: begin
          if (cur_id) begin
            ack1 <= 1'b1;
            err1 <= err_flag;
          end else begin
            ack0 <= 1'b1;
            err0 <= err_flag;
          end
          // read_data is valid while MemRead is high, i.e. right up to this edge.
          if (MemRead) begin
            if (cur_id) rdata1 <= read_data;
            else        rdata0 <= read_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Self-checking bench for data_memory_arbiter: directed scenarios plus randomized
// traffic scored against a transaction-level model (arbitration rule, memory array).
module tb_data_memory_arbiter;

  localparam int DEPTH = 256;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, err0, err1, MemWrite, MemRead;
  logic [31:0] rdata0, rdata1, address, write_data, read_data;

  int total = 0;
  int bad   = 0;

  // Memory behind the arbiter; unwritten words return a fixed address-derived pattern.
  bit [31:0] mem     [DEPTH];
  bit        written [DEPTH];

  // Reference model state.
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] rdata_m [2];
  logic        last_m;
  logic [31:0] last_addr_m;

  data_memory_arbiter #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1),
    .MemWrite(MemWrite), .MemRead(MemRead),
    .address(address), .write_data(write_data), .read_data(read_data)
  );

  always #5 clock = ~clock;

  assign read_data = MemRead ? (written[address[7:0]] ? mem[address[7:0]]
                                                      : (address ^ 32'hA5A5_0000))
                             : 32'hDEAD_BEEF;

  always @(posedge clock) begin
    if (MemWrite) begin
      mem[address[7:0]]     <= write_data;
      written[address[7:0]] <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_memwrite"}, MemWrite, 0);
    check({tag, "_memread"},  MemRead,  0);
    check({tag, "_acks"},     {ack1, ack0}, 0);
    check({tag, "_errs"},     {err1, err0}, 0);
    check({tag, "_address"},  address, 0);
    check({tag, "_wdata"},    write_data, 0);
    check({tag, "_rdata0"},   rdata0, 0);
    check({tag, "_rdata1"},   rdata1, 0);
  endtask

  // Requester i issues cnt_i back-to-back transactions with fixed fields, holding req
  // until its last ack. Requester 1 raises req start1 negedges in. Each ack is scored
  // against the request levels that were present when the grant edge sampled them.
  task automatic run(input int cnt0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                     input int cnt1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                     input int start1, input int first_lat);
    int          left0, left1, t, last_t, strobes, exp_strobes, first_stb;
    logic [1:0]  drv[$];
    logic [1:0]  pend;
    logic        k, e, w, exp_w;
    logic [31:0] a, d;
    left0 = cnt0; left1 = cnt1; t = 0; last_t = -1; strobes = 0; first_stb = -1;
    exp_strobes = ((a0 < DEPTH) ? cnt0 : 0) + ((a1 < DEPTH) ? cnt1 : 0);
    we0 = w0; addr0 = a0; wdata0 = d0;
    we1 = w1; addr1 = a1; wdata1 = d1;
    req0 = (left0 > 0);
    req1 = (start1 == 0) && (left1 > 0);
    drv.push_back({req1, req0});
    while ((left0 > 0 || left1 > 0) && t < 100) begin
      @(negedge clock);
      t++;
      if (MemRead || MemWrite) begin
        strobes++;
        if (first_stb < 0) first_stb = t;
      end
      if (ack0 || ack1) begin
        check("ack_onehot", 32'(ack0 & ack1), 0);
        k = ack1;
        if (t < 3) begin
          check("ack_too_early", t, 3);
        end else begin
          pend = drv[t-3];
          check("pending_at_grant", 32'(pend != 2'b00), 1);
          exp_w = (pend == 2'b11) ? ~last_m : pend[1];
          if (pend != 2'b00) check("grant_id", 32'(k), 32'(exp_w));
        end
        if (first_lat >= 0 && last_t < 0) begin
          check("first_ack_latency", t, first_lat);
          check("first_strobe_time", first_stb, (exp_strobes > 0) ? first_lat - 1 : -1);
        end
        if (last_t >= 0) begin
          if (drv[last_t] != 2'b00) check("ack_spacing", t - last_t, 3);
          else                      check("ack_min_spacing", 32'((t - last_t) >= 3), 1);
        end
        last_t = t;
        a = k ? a1 : a0;
        d = k ? d1 : d0;
        w = k ? w1 : w0;
        e = (a >= DEPTH);
        check(k ? "err1" : "err0", k ? err1 : err0, 32'(e));
        last_m = k;
        if (!e) begin
          last_addr_m = a;
          if (w) ref_mem[a[7:0]] = d;
          else   rdata_m[k] = ref_mem[a[7:0]];
        end
        check("rdata0", rdata0, rdata_m[0]);
        check("rdata1", rdata1, rdata_m[1]);
        if (k) begin
          left1--;
          if (left1 == 0) req1 = 1'b0;
        end else begin
          left0--;
          if (left0 == 0) req0 = 1'b0;
        end
      end
      if (start1 > 0 && t == start1 && left1 > 0) req1 = 1'b1;
      drv.push_back({req1, req0});
    end
    check("no_timeout", 32'(t < 100), 1);
    check("strobe_cycles", strobes, exp_strobes);
    check("address_hold", address, last_addr_m);
    @(negedge clock);
    check("ack_width", {ack1, ack0}, 0);
  endtask

  initial begin
    int          c0, c1;
    logic [31:0] ra0, ra1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'(i) ^ 32'hA5A5_0000;
    rdata_m[0] = '0; rdata_m[1] = '0; last_m = 1'b1; last_addr_m = '0;

    // Reset state.
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Simultaneous requests after reset: 0 first, then 1; held twice each alternates.
    run(1, 1'b1, 32'd3, 32'h1111_0003, 1, 1'b1, 32'd4, 32'h2222_0004, 0, 3);
    run(2, 1'b0, 32'd4, 32'h0, 2, 1'b0, 32'd3, 32'h0, 0, 3);

    // Write then read back through requester 0.
    run(1, 1'b1, 32'd1, 32'hFFFF_FFF1, 0, 1'b0, 32'd0, 32'h0, 0, 3);
    run(1, 1'b0, 32'd1, 32'h0, 0, 1'b0, 32'd0, 32'h0, 0, 3);
    check("readback_rdata0", rdata0, 32'hFFFF_FFF1);

    // Out-of-range read on requester 1: error, no strobe, rdata1 untouched.
    run(0, 1'b0, 32'd0, 32'h0, 1, 1'b0, DEPTH, 32'h0, 0, 3);
    run(0, 1'b0, 32'd0, 32'h0, 1, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 0, 3);

    // Continuous requester 0 with requester 1 joining mid-stream.
    run(4, 1'b0, 32'd1, 32'h0, 1, 1'b1, 32'd9, 32'hCAFE_0009, 1, 3);

    // Randomized traffic, addresses clustered so reads hit earlier writes.
    for (int n = 0; n < 30; n++) begin
      c0 = $urandom_range(0, 2);
      c1 = $urandom_range(0, 2);
      if (c0 == 0 && c1 == 0) c0 = 1;
      ra0 = ($urandom_range(0, 7) == 0) ? DEPTH + $urandom_range(0, 1000) : $urandom_range(0, 15);
      ra1 = ($urandom_range(0, 7) == 0) ? DEPTH + $urandom_range(0, 1000) : $urandom_range(0, 15);
      run(c0, 1'($urandom), ra0, $urandom, c1, 1'($urandom), ra1, $urandom,
          (c1 > 0) ? $urandom_range(0, 4) : 0, -1);
    end

    // Reset while a write strobe is on the bus.
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd7; wdata0 = 32'h7777_7777;
    req1 = 1'b0;
    for (int i = 0; i < 10 && !MemWrite; i++) @(negedge clock);
    check("abort_strobe_seen", MemWrite, 1);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("abort");
    @(negedge clock);
    check("abort_no_ack", {ack1, ack0}, 0);
    reset_n = 1'b1;
    rdata_m[0] = '0; rdata_m[1] = '0; last_m = 1'b1; last_addr_m = '0;

    // The aborted requester keeps req high and is served; then contention restarts at 0.
    run(1, 1'b1, 32'd7, 32'h7777_7777, 0, 1'b0, 32'd0, 32'h0, 0, 3);
    run(1, 1'b0, 32'd7, 32'h0, 1, 1'b0, 32'd1, 32'h0, 0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_memory_arbiter.md
DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

Interface
REQ-001 Parameter DEPTH, default 256: number of valid 32-bit words in the shared data memory.
REQ-002 Port clock  input  1: single clock; all state updates on rising edge.
REQ-003 Port reset_n  input  1: asynchronous, active-low reset.
REQ-004 Ports req0 / req1  input  1: access request from requester 0 (CPU) / requester 1 (loader).
REQ-005 Ports we0 / we1  input  1: 1 = write, 0 = read, per requester.
REQ-006 Ports addr0 / addr1  input  32: word address, per requester.
REQ-007 Ports wdata0 / wdata1  input  32: write data, per requester.
REQ-008 Ports ack0 / ack1  output  1: one-cycle completion pulse, per requester.
REQ-009 Ports err0 / err1  output  1: valid with ack; 1 = address out of range, access dropped.
REQ-010 Ports rdata0 / rdata1  output  32: read data, valid with ack on a read.
REQ-011 Ports MemWrite, MemRead  output  1: memory strobes.
REQ-012 Ports address, write_data  output  32: memory address and write data.
REQ-013 Port read_data  input  32: memory read data, valid combinationally while MemRead=1.

Function
REQ-014 FSM states: IDLE, ACCESS, RESP; one transaction in flight at a time.
REQ-015 IDLE: if any req is high, latch the winner's id, we, addr and wdata; go to ACCESS; otherwise stay in IDLE.
REQ-016 Arbitration: a single requester wins alone; simultaneous requests go to the requester not granted last (round-robin).
REQ-017 last_grant updates only on grant, not on error.
REQ-018 ACCESS, in range (addr < DEPTH): drive MemWrite=we, MemRead=~we, address and write_data from latches for exactly one cycle.
REQ-019 ACCESS, in range: capture read_data into the winner's rdata on a read; go to RESP.
REQ-020 ACCESS, out of range (addr >= DEPTH): keep both strobes 0, set the error flag, go to RESP.
REQ-021 RESP: pulse the winner's ack for one cycle, with err=error flag; go to IDLE.
REQ-022 Latency: request sampled in IDLE at edge N; strobes active N+1..N+2; ack high N+2..N+3; next grant no earlier than edge N+3.
REQ-023 Handshake: the requester holds req, we, addr and wdata stable until ack.
REQ-024 A req still high in the IDLE cycle after ack is a new request.
REQ-025 Outside ACCESS, MemWrite=MemRead=0.
REQ-026 address and write_data hold their last value when idle.
REQ-027 rdataX holds its value until the next read completes for that requester.
REQ-028 A write leaves rdataX unchanged.
REQ-029 The non-granted requester's ack and err stay 0.
REQ-030 A request arriving while a transaction is busy waits; no request is lost while req is held.

Reset
REQ-031 reset_n=0 immediately forces: state=IDLE, MemWrite=MemRead=0, ack0=ack1=0, err0=err1=0.
REQ-032 reset_n=0 also forces: address=write_data=0, rdata0=rdata1=0, latched fields=0.
REQ-033 Reset sets last_grant=1, so requester 0 wins the first simultaneous request.
REQ-034 Reset in the middle of a transaction aborts it: no ack, and the strobe drops in the same cycle.
REQ-035 After reset_n returns to 1, a requester whose transaction was aborted re-requests by holding req.

Verification
REQ-036 req0 write addr=1, wdata=32'hFFFFFFF1, then req0 read addr=1 -> second ack0 carries rdata0=32'hFFFFFFF1, err0=0.
REQ-037 req0 and req1 asserted together after reset -> requester 0 is acked first, then requester 1; repeated together -> grants alternate 0,1,0,1.
REQ-038 req1 read at addr=DEPTH (256) -> MemRead is never asserted; ack1=1 with err1=1; rdata1 unchanged.
REQ-039 Single read, strobe timing -> MemRead high exactly one cycle; ack 2 edges after the request is sampled; ack width exactly one cycle.
REQ-040 reset_n pulsed low during ACCESS -> MemWrite drops immediately; no ack; every output at its reset value.
REQ-041 req0 held high continuously -> a new transaction every 3 cycles; req1 asserted meanwhile is granted within one transaction.
